// File: rtl/fsm_path_driver.sv
// Path-command stimulus driver for the INIT/READ1/READ2/READ3 recognizer, with an
// optional shadow recognizer and mismatch checker compiled in by FSM_PATH_CHK_EN.
module fsm_path_driver #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_path,
  input  logic [3:0]           cmd_loops,
  output logic                 drv_in1,
  output logic                 drv_in2,
  output logic                 drv_in3,
  input  logic                 mon_out1,
  input  logic                 mon_out2,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_err,
  output logic                 chk_err,
  output logic [ERR_CNT_W-1:0] chk_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } ctl_state_t;

  ctl_state_t r_state;
  logic [1:0] r_path;
  logic [4:0] r_remain;
  logic [2:0] r_drv;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;
  logic       r_cmd_err;

  // r_remain counts vectors still to emit after the one currently on r_drv.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_path    <= 2'd0;
      r_remain  <= 5'd0;
      r_drv     <= 3'b000;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_drv <= 3'b000;
          if (cmd_valid && r_ready) begin
            r_path <= cmd_path;
            case (cmd_path)
              2'd0: begin
                r_drv    <= 3'b110;
                r_remain <= {1'b0, cmd_loops} + 5'd1;
                r_state  <= S_RUN;
                r_ready  <= 1'b0;
                r_busy   <= 1'b1;
              end
              2'd1: begin
                r_drv    <= 3'b100;
                r_remain <= 5'd2;
                r_state  <= S_RUN;
                r_ready  <= 1'b0;
                r_busy   <= 1'b1;
              end
              2'd2: begin
                r_drv    <= 3'b000;
                r_remain <= {1'b0, cmd_loops};
                r_state  <= S_RUN;
                r_ready  <= 1'b0;
                r_busy   <= 1'b1;
              end
              default: r_cmd_err <= 1'b1;
            endcase
          end
        end
        S_RUN: begin
          if (r_remain == 5'd0) begin
            r_drv   <= 3'b000;
            r_state <= S_FIN;
          end else begin
            r_remain <= r_remain - 5'd1;
            case (r_path)
              2'd0:    r_drv <= (r_remain == 5'd1) ? 3'b010 : 3'b001;
              2'd1:    r_drv <= (r_remain == 5'd1) ? 3'b000 : 3'b100;
              default: r_drv <= 3'b000;
            endcase
          end
        end
        S_FIN: begin
          r_drv   <= 3'b000;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_drv   <= 3'b000;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_err   = r_cmd_err;
  assign drv_in1   = r_drv[2];
  assign drv_in2   = r_drv[1];
  assign drv_in3   = r_drv[0];

`ifdef FSM_PATH_CHK_EN
  typedef enum logic [1:0] {
    SH_INIT  = 2'd0,
    SH_READ1 = 2'd1,
    SH_READ2 = 2'd2,
    SH_READ3 = 2'd3
  } shadow_state_t;

  shadow_state_t        r_shadow;
  logic                 r_chk_err;
  logic [ERR_CNT_W-1:0] r_chk_cnt;
  logic [1:0]           w_exp;

  always_comb begin
    w_exp = 2'b10;
    case (r_shadow)
      SH_INIT:  w_exp = 2'b10;
      SH_READ1: w_exp = 2'b01;
      SH_READ2: w_exp = 2'b11;
      SH_READ3: w_exp = 2'b11;
      default:  w_exp = 2'b10;
    endcase
  end

  // Shadow and monitored outputs both reflect pre-edge state, so they compare directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= SH_INIT;
      r_chk_err <= 1'b0;
      r_chk_cnt <= '0;
    end else begin
      case (r_shadow)
        SH_INIT: begin
          if (r_drv[2] && r_drv[1])       r_shadow <= SH_READ1;
          else if (r_drv[2] && !r_drv[1]) r_shadow <= SH_READ2;
        end
        SH_READ1: begin
          if (r_drv[0])      r_shadow <= SH_READ1;
          else if (r_drv[1]) r_shadow <= SH_INIT;
        end
        SH_READ2: if (|r_drv) r_shadow <= SH_READ3;
        SH_READ3: r_shadow <= SH_INIT;
        default:  r_shadow <= SH_INIT;
      endcase
      if ({mon_out1, mon_out2} != w_exp) begin
        r_chk_err <= 1'b1;
        if (r_chk_cnt != {ERR_CNT_W{1'b1}}) r_chk_cnt <= r_chk_cnt + 1'b1;
      end
    end
  end

  assign chk_err     = r_chk_err;
  assign chk_err_cnt = r_chk_cnt;
`else
  wire w_unused_mon = mon_out1 ^ mon_out2;
  assign chk_err     = 1'b0;
  assign chk_err_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_path_driver.sv
// Directed bench for fsm_path_driver with a behavioural recognizer on mon_out*.
module tb_fsm_path_driver;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_path = 2'd0;
  logic [3:0] cmd_loops = 4'd0;
  logic       drv_in1, drv_in2, drv_in3;
  logic       mon_out1, mon_out2;
  logic       busy, done, cmd_err, chk_err;
  logic [7:0] chk_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Recognizer under observation; r_force pins out1 low to provoke mismatches.
  logic [1:0] rec_state;
  logic       r_force = 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rec_state <= 2'd0;
    else begin
      case (rec_state)
        2'd0: if (drv_in1 && drv_in2) rec_state <= 2'd1;
              else if (drv_in1) rec_state <= 2'd2;
        2'd1: if (drv_in3) rec_state <= 2'd1;
              else if (drv_in2) rec_state <= 2'd0;
        2'd2: if (drv_in1 || drv_in2 || drv_in3) rec_state <= 2'd3;
        default: rec_state <= 2'd0;
      endcase
    end
  end

  assign mon_out1 = (rec_state == 2'd0 || rec_state[1]) && !r_force;
  assign mon_out2 = (rec_state != 2'd0);

  always #5 clock = ~clock;

  fsm_path_driver #(.ERR_CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_path(cmd_path), .cmd_loops(cmd_loops),
    .drv_in1(drv_in1), .drv_in2(drv_in2), .drv_in3(drv_in3),
    .mon_out1(mon_out1), .mon_out2(mon_out2),
    .busy(busy), .done(done), .cmd_err(cmd_err),
    .chk_err(chk_err), .chk_err_cnt(chk_err_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    n_tests++;
    if ({cmd_ready, busy, done, cmd_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl: ready/busy/done/err=%b required 1000", {cmd_ready, busy, done, cmd_err});
    end
    n_tests++;
    if ({drv_in1, drv_in2, drv_in3} !== 3'b000 || chk_err !== 1'b0 || chk_err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_out: drv=%b chk_err=%b cnt=%0d required 000/0/0",
               {drv_in1, drv_in2, drv_in3}, chk_err, chk_err_cnt);
    end
    reset_n = 1'b1;
    tick();
    $display("[TB] reset released");
  endtask

  task automatic test_path0();
    logic [2:0] exp_v [4] = '{3'b110, 3'b001, 3'b001, 3'b010};
    cmd_valid = 1'b1; cmd_path = 2'd0; cmd_loops = 4'd2;
    tick();
    cmd_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if ({drv_in1, drv_in2, drv_in3} !== exp_v[j] || busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL path0_vec%0d: drv=%b busy=%b done=%b ready=%b required %b/1/0/0",
                 j, {drv_in1, drv_in2, drv_in3}, busy, done, cmd_ready, exp_v[j]);
      end
      tick();
    end
    n_tests++;
    if ({drv_in1, drv_in2, drv_in3} !== 3'b000 || busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL path0_fin: drv=%b busy=%b done=%b ready=%b required 000/1/0/0",
               {drv_in1, drv_in2, drv_in3}, busy, done, cmd_ready);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || chk_err !== 1'b0) begin
      n_fail++;
      $display("FAIL path0_done: done=%b busy=%b ready=%b chk_err=%b required 1/0/1/0",
               done, busy, cmd_ready, chk_err);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL path0_pulse: done=%b required 0", done);
    end
    $display("[TB] path 0 loops=2 completed");
  endtask

  task automatic test_path1();
    logic [2:0] exp_v [3] = '{3'b100, 3'b100, 3'b000};
    cmd_valid = 1'b1; cmd_path = 2'd1; cmd_loops = 4'd7;
    tick();
    cmd_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_tests++;
      if ({drv_in1, drv_in2, drv_in3} !== exp_v[j] || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL path1_vec%0d: drv=%b busy=%b done=%b required %b/1/0",
                 j, {drv_in1, drv_in2, drv_in3}, busy, done, exp_v[j]);
      end
      tick();
    end
    n_tests++;
    if (done !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL path1_fin: done=%b ready=%b required 0/0", done, cmd_ready);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || chk_err !== 1'b0) begin
      n_fail++;
      $display("FAIL path1_done: done=%b busy=%b chk_err=%b required 1/0/0", done, busy, chk_err);
    end
    tick();
    $display("[TB] path 1 completed");
  endtask

  task automatic test_illegal();
    cmd_valid = 1'b1; cmd_path = 2'd3; cmd_loops = 4'd5;
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if (cmd_err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || {drv_in1, drv_in2, drv_in3} !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal_err: err=%b ready=%b busy=%b drv=%b required 1/1/0/000",
               cmd_err, cmd_ready, busy, {drv_in1, drv_in2, drv_in3});
    end
    tick();
    n_tests++;
    if (cmd_err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse: err=%b busy=%b done=%b required 0/0/0", cmd_err, busy, done);
    end
    $display("[TB] illegal path 3 rejected");
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_path = 2'd2; cmd_loops = 4'd0;
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || {drv_in1, drv_in2, drv_in3} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_hold: busy=%b drv=%b required 1/000", busy, {drv_in1, drv_in2, drv_in3});
    end
    tick();
    tick();
    n_tests++;
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b ready=%b required 1/1", done, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_path = 2'd1;
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if ({drv_in1, drv_in2, drv_in3} !== 3'b100 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: drv=%b busy=%b done=%b required 100/1/0",
               {drv_in1, drv_in2, drv_in3}, busy, done);
    end
    for (int j = 0; j < 4; j++) tick();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_done: done=%b required 1", done);
    end
    tick();
    $display("[TB] back-to-back hold then path 1 completed");
  endtask

  task automatic test_mismatch();
    logic [7:0] exp_cnt3, exp_sat;
    logic       exp_flag;
`ifdef FSM_PATH_CHK_EN
    exp_cnt3 = 8'd3; exp_sat = 8'd255; exp_flag = 1'b1;
`else
    exp_cnt3 = 8'd0; exp_sat = 8'd0; exp_flag = 1'b0;
`endif
    // Forced out1=0 differs from the shadow only while it sits in INIT:
    // the accept edge, the next one, and the done edge -> 3 mismatches.
    r_force = 1'b1;
    cmd_valid = 1'b1; cmd_path = 2'd0; cmd_loops = 4'd2;
    tick();
    cmd_valid = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    n_tests++;
    if (done !== 1'b1 || chk_err !== exp_flag || chk_err_cnt !== exp_cnt3) begin
      n_fail++;
      $display("FAIL mismatch_count: done=%b chk_err=%b cnt=%0d required 1/%b/%0d",
               done, chk_err, chk_err_cnt, exp_flag, exp_cnt3);
    end
    for (int j = 0; j < 300; j++) tick();
    n_tests++;
    if (chk_err_cnt !== exp_sat || chk_err !== exp_flag) begin
      n_fail++;
      $display("FAIL mismatch_saturate: cnt=%0d chk_err=%b required %0d/%b",
               chk_err_cnt, chk_err, exp_sat, exp_flag);
    end
    r_force = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (chk_err !== 1'b0 || chk_err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mismatch_clear: chk_err=%b cnt=%0d required 0/0", chk_err, chk_err_cnt);
    end
    tick();
    reset_n = 1'b1;
    tick();
    $display("[TB] forced mismatch run, count=%0d", exp_sat);
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    cmd_valid = 1'b1; cmd_path = 2'd1; cmd_loops = 4'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({drv_in1, drv_in2, drv_in3} !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_state: drv=%b busy=%b done=%b ready=%b required 000/0/0/1",
               {drv_in1, drv_in2, drv_in3}, busy, done, cmd_ready);
    end
    tick();
    reset_n = 1'b1;
    seen_done = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      seen_done = seen_done | done | busy;
    end
    n_tests++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_nodone: done/busy seen=%b required 0", seen_done);
    end
    cmd_valid = 1'b1; cmd_path = 2'd2; cmd_loops = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if ({drv_in1, drv_in2, drv_in3} !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_vec%0d: drv=%b busy=%b done=%b required 000/1/0",
                 j, {drv_in1, drv_in2, drv_in3}, busy, done);
      end
      tick();
    end
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_fin: done=%b busy=%b required 0/1", done, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_done: done=%b busy=%b required 1/0", done, busy);
    end
    tick();
    $display("[TB] mid-command reset, then path 2 loops=3 completed");
  endtask

  initial begin
    test_reset();
    test_path0();
    test_path1();
    test_illegal();
    test_back_to_back();
    test_mismatch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
